// File: rtl/q_table_update_pkg.sv
// Shared parameters, encodings and types for the grid-world Q-learning value stage.
package q_table_update_pkg;

   localparam int STATES_WIDTH  = 5;
   localparam int ACTIONS_WIDTH = 2;
   localparam int DATA_WIDTH    = 16;
   localparam int FRAC_BITS     = 8;
   localparam int STATES        = 25;
   localparam int ACTIONS       = 4;
   localparam int GAMMA         = 230;
   localparam int ALPHA_SHIFT   = 1;

   // Headroom for GAMMA x Q before the shift back to DATA_WIDTH.
   localparam int CALC_W = DATA_WIDTH + FRAC_BITS + 2;

   localparam logic [STATES_WIDTH-1:0] STATES_IDX = STATES_WIDTH'(STATES);
   localparam logic signed [CALC_W-1:0] GAMMA_W  = CALC_W'(GAMMA);

   typedef enum logic [ACTIONS_WIDTH-1:0] {
      ACT_UP    = 2'd0,
      ACT_DOWN  = 2'd1,
      ACT_RIGHT = 2'd2,
      ACT_LEFT  = 2'd3
   } action_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_CALC,
      ST_WRITE,
      ST_DONE
   } fsm_e;

   typedef struct packed {
      logic [STATES_WIDTH-1:0]  st;
      logic [ACTIONS_WIDTH-1:0] at;
      logic [DATA_WIDTH-1:0]    rt;
      logic [STATES_WIDTH-1:0]  nst;
   } tuple_t;

endpackage

// File: rtl/q_sat_add.sv
// Signed add of two IN_W-bit words, saturated to a signed OUT_W-bit result.
module q_sat_add #(
   parameter int IN_W  = 26,
   parameter int OUT_W = 16
) (
   input  logic [IN_W-1:0]  a,
   input  logic [IN_W-1:0]  b,
   output logic [OUT_W-1:0] y
);

   localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((2**(OUT_W-1)) - 1);
   localparam logic signed [IN_W:0] MINV = (IN_W+1)'(-(2**(OUT_W-1)));

   logic signed [IN_W:0] sum;

   // One extra bit so the add itself can never wrap.
   assign sum = $signed({a[IN_W-1], a}) + $signed({b[IN_W-1], b});

   always_comb begin
      y = sum[OUT_W-1:0];
      if (sum > MAXV)
         y = {1'b0, {(OUT_W-1){1'b1}}};
      else if (sum < MINV)
         y = {1'b1, {(OUT_W-1){1'b0}}};
   end

endmodule

// File: rtl/q_table_update.sv
// Q-learning value stage: scans max Q of next state, applies the fixed-point
// Bellman update to Q(st,at), and reports the greedy next action.
module q_table_update
   import q_table_update_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_valid,
   input  logic [STATES_WIDTH-1:0]  i_st,
   input  logic [ACTIONS_WIDTH-1:0] i_at,
   input  logic [DATA_WIDTH-1:0]    i_rt,
   input  logic [STATES_WIDTH-1:0]  i_next_st,
   input  logic                     i_clear,
   input  logic [STATES_WIDTH-1:0]  i_rd_st,
   input  logic [ACTIONS_WIDTH-1:0] i_rd_at,
   output logic                     o_ready,
   output logic                     o_valid,
   output logic                     o_err,
   output logic [ACTIONS_WIDTH-1:0] o_at_max,
   output logic [DATA_WIDTH-1:0]    o_q_max,
   output logic [DATA_WIDTH-1:0]    o_rd_q
);

   logic [STATES-1:0][ACTIONS-1:0][DATA_WIDTH-1:0] q_tab;

   fsm_e                      state, nxt;
   tuple_t                    tup;
   logic [ACTIONS_WIDTH-1:0]  scan_k;
   logic [ACTIONS_WIDTH-1:0]  at_max_r;
   logic signed [DATA_WIDTH-1:0] q_max_r;
   logic signed [DATA_WIDTH:0]   delta, delta_r, delta_sh;
   logic [DATA_WIDTH-1:0]     cur_q, q_old, target, q_new;
   logic [CALC_W-1:0]         rt_ext, q_old_ext, dsh_ext;
   logic signed [CALC_W-1:0]  q_max_ext, prod, disc;
   logic                      in_range, take;

   assign in_range = (i_st < STATES_IDX) && (i_next_st < STATES_IDX);
   assign take     = (state == ST_IDLE) && i_valid && !i_clear;
   assign cur_q    = q_tab[tup.nst][scan_k];
   assign q_old    = q_tab[tup.st][tup.at];

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         ST_IDLE:  if (take && in_range) nxt = ST_SCAN;
         ST_SCAN:  if (&scan_k) nxt = ST_CALC;
         ST_CALC:  nxt = ST_WRITE;
         ST_WRITE: nxt = ST_DONE;
         ST_DONE:  nxt = ST_IDLE;
         default:  nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_ready = (state == ST_IDLE);
      o_valid = (state == ST_DONE);
   end

   // ---------------- Bellman arithmetic ----------------
   assign q_max_ext = {{(CALC_W-DATA_WIDTH){q_max_r[DATA_WIDTH-1]}}, q_max_r};
   assign prod      = q_max_ext * GAMMA_W;
   assign disc      = prod >>> FRAC_BITS;
   assign rt_ext    = {{(CALC_W-DATA_WIDTH){tup.rt[DATA_WIDTH-1]}}, tup.rt};

   q_sat_add #(.IN_W(CALC_W), .OUT_W(DATA_WIDTH)) u_target (
      .a (rt_ext),
      .b (disc),
      .y (target)
   );

   assign delta = $signed({target[DATA_WIDTH-1], target}) - $signed({q_old[DATA_WIDTH-1], q_old});

   // Arithmetic shift floors negative deltas toward -inf.
   assign delta_sh  = delta_r >>> ALPHA_SHIFT;
   assign dsh_ext   = {{(CALC_W-DATA_WIDTH-1){delta_sh[DATA_WIDTH]}}, delta_sh};
   assign q_old_ext = {{(CALC_W-DATA_WIDTH){q_old[DATA_WIDTH-1]}}, q_old};

   q_sat_add #(.IN_W(CALC_W), .OUT_W(DATA_WIDTH)) u_qnew (
      .a (q_old_ext),
      .b (dsh_ext),
      .y (q_new)
   );

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tup      <= '0;
         scan_k   <= '0;
         q_max_r  <= '0;
         at_max_r <= '0;
         delta_r  <= '0;
         o_at_max <= '0;
         o_q_max  <= '0;
         o_err    <= 1'b0;
      end else begin
         o_err <= take && !in_range;
         unique case (state)
            ST_IDLE: begin
               scan_k <= '0;
               if (take) tup <= '{st: i_st, at: i_at, rt: i_rt, nst: i_next_st};
            end
            ST_SCAN: begin
               // Strict compare keeps the lowest action index on ties.
               if (scan_k == '0 || $signed(cur_q) > q_max_r) begin
                  q_max_r  <= $signed(cur_q);
                  at_max_r <= scan_k;
               end
               scan_k <= scan_k + ACTIONS_WIDTH'(1);
            end
            ST_CALC:  delta_r <= delta;
            ST_WRITE: begin
               o_at_max <= at_max_r;
               o_q_max  <= q_max_r;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q_tab <= '0;
      else if (state == ST_IDLE && i_clear)
         q_tab <= '0;
      else if (state == ST_WRITE)
         q_tab[tup.st][tup.at] <= q_new;
   end

   // Readback sees the table before any write landing on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         o_rd_q <= '0;
      else
         o_rd_q <= (i_rd_st < STATES_IDX) ? q_tab[i_rd_st][i_rd_at] : '0;
   end

endmodule

// File: tb/tb_q_table_update.sv
// Directed bench for q_table_update: Bellman values, timing, saturation,
// reject path, clear, and asynchronous reset mid-scan.
module tb_q_table_update;
   import q_table_update_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     i_valid = 1'b0;
   logic [STATES_WIDTH-1:0]  i_st = '0;
   logic [ACTIONS_WIDTH-1:0] i_at = '0;
   logic [DATA_WIDTH-1:0]    i_rt = '0;
   logic [STATES_WIDTH-1:0]  i_next_st = '0;
   logic                     i_clear = 1'b0;
   logic [STATES_WIDTH-1:0]  i_rd_st = '0;
   logic [ACTIONS_WIDTH-1:0] i_rd_at = '0;
   logic                     o_ready, o_valid, o_err;
   logic [ACTIONS_WIDTH-1:0] o_at_max;
   logic [DATA_WIDTH-1:0]    o_q_max, o_rd_q;

   int n_chk = 0;
   int n_fail = 0;
   int vld_cnt = 0;
   int v0;
   logic [DATA_WIDTH-1:0] acc;

   q_table_update dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_st(i_st), .i_at(i_at),
      .i_rt(i_rt), .i_next_st(i_next_st), .i_clear(i_clear), .i_rd_st(i_rd_st),
      .i_rd_at(i_rd_at), .o_ready(o_ready), .o_valid(o_valid), .o_err(o_err),
      .o_at_max(o_at_max), .o_q_max(o_q_max), .o_rd_q(o_rd_q)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (o_valid) vld_cnt++;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Sends one tuple and checks latency, max outputs and readback around the write.
   task automatic run_tuple(input string tag, input logic [4:0] st, input logic [1:0] at,
                            input logic [4:0] nst, input logic [15:0] rt,
                            input logic [15:0] e_qmax, input logic [1:0] e_amax,
                            input logic [15:0] e_old, input logic [15:0] e_new);
      int vcyc;
      @(negedge clk);
      chk({tag, "_ready"}, 32'(o_ready), 32'd1);
      i_valid = 1'b1; i_st = st; i_at = at; i_next_st = nst; i_rt = rt;
      i_rd_st = st; i_rd_at = at;
      @(posedge clk); #1 i_valid = 1'b0;
      vcyc = -1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (o_valid && vcyc < 0) vcyc = c;
         if (c == 7) begin
            chk({tag, "_qmax"}, 32'(o_q_max), 32'(e_qmax));
            chk({tag, "_amax"}, 32'(o_at_max), 32'(e_amax));
            chk({tag, "_rd_old"}, 32'(o_rd_q), 32'(e_old));
         end
         if (c == 8) begin
            chk({tag, "_ready8"}, 32'(o_ready), 32'd1);
            chk({tag, "_rd_new"}, 32'(o_rd_q), 32'(e_new));
         end
      end
      chk({tag, "_vcyc"}, 32'(vcyc), 32'd7);
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] st, input logic [1:0] at,
                         input logic [15:0] exp);
      @(negedge clk); i_rd_st = st; i_rd_at = at;
      @(negedge clk); chk(tag, 32'(o_rd_q), 32'(exp));
   endtask

   task automatic reject(input string tag, input logic [4:0] st, input logic [4:0] nst);
      @(negedge clk);
      i_valid = 1'b1; i_st = st; i_at = 2'd0; i_next_st = nst; i_rt = 16'h0100;
      @(posedge clk); #1 i_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_err"}, 32'(o_err), 32'd1);
      chk({tag, "_ready"}, 32'(o_ready), 32'd1);
      @(negedge clk);
      chk({tag, "_err_clr"}, 32'(o_err), 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_err",   32'(o_err),   32'd0);
      chk("rst_amax",  32'(o_at_max), 32'd0);
      chk("rst_qmax",  32'(o_q_max), 32'd0);
      chk("rst_rdq",   32'(o_rd_q),  32'd0);
      rst_n = 1'b1;

      run_tuple("t1", 5'd0, 2'd1, 5'd5, 16'h0A00, 16'h0000, 2'd0, 16'h0000, 16'h0500);
      run_tuple("t2", 5'd5, 2'd0, 5'd0, 16'h0000, 16'h0500, 2'd1, 16'h0000, 16'h023F);
      run_tuple("neg", 5'd3, 2'd1, 5'd8, 16'hF000, 16'h0000, 2'd0, 16'h0000, 16'hF800);
      run_tuple("floor", 5'd4, 2'd3, 5'd10, 16'hFFFF, 16'h0000, 2'd0, 16'h0000, 16'hFFFF);

      // Build Q[8] = {5FFF, 0, 0, 5FFF}: equal maxima at actions 0 and 3.
      run_tuple("pre0a", 5'd8, 2'd0, 5'd20, 16'h7FFF, 16'h0000, 2'd0, 16'h0000, 16'h3FFF);
      run_tuple("pre0b", 5'd8, 2'd0, 5'd20, 16'h7FFF, 16'h0000, 2'd0, 16'h3FFF, 16'h5FFF);
      run_tuple("pre3a", 5'd8, 2'd3, 5'd20, 16'h7FFF, 16'h0000, 2'd0, 16'h0000, 16'h3FFF);
      run_tuple("pre3b", 5'd8, 2'd3, 5'd20, 16'h7FFF, 16'h0000, 2'd0, 16'h3FFF, 16'h5FFF);
      run_tuple("sat", 5'd9, 2'd2, 5'd8, 16'h7FFF, 16'h5FFF, 2'd0, 16'h0000, 16'h3FFF);
      run_tuple("self", 5'd8, 2'd0, 5'd8, 16'h7FFF, 16'h5FFF, 2'd0, 16'h5FFF, 16'h6FFF);

      v0 = vld_cnt;
      reject("rej_st", 5'd27, 5'd0);
      reject("rej_nst", 5'd2, 5'd25);
      repeat (8) @(negedge clk);
      chk("rej_novalid", 32'(vld_cnt - v0), 32'd0);
      rd_chk("rej_tab", 5'd0, 2'd1, 16'h0500);

      // i_valid held through the whole update must yield exactly one write.
      @(negedge clk);
      v0 = vld_cnt;
      i_valid = 1'b1; i_st = 5'd1; i_at = 2'd2; i_next_st = 5'd10; i_rt = 16'h0200;
      repeat (7) @(posedge clk);
      #1 i_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("hold_one_valid", 32'(vld_cnt - v0), 32'd1);
      rd_chk("hold_q", 5'd1, 2'd2, 16'h0100);

      // Clear wins over a simultaneous valid.
      @(negedge clk);
      v0 = vld_cnt;
      i_clear = 1'b1; i_valid = 1'b1; i_st = 5'd0; i_at = 2'd0; i_next_st = 5'd0; i_rt = 16'h0400;
      @(posedge clk); #1 begin i_clear = 1'b0; i_valid = 1'b0; end
      repeat (10) @(negedge clk);
      chk("clr_novalid", 32'(vld_cnt - v0), 32'd0);
      rd_chk("clr_q80", 5'd8, 2'd0, 16'h0000);
      rd_chk("clr_q01", 5'd0, 2'd1, 16'h0000);

      run_tuple("r1", 5'd0, 2'd1, 5'd5, 16'h0A00, 16'h0000, 2'd0, 16'h0000, 16'h0500);
      run_tuple("r2", 5'd5, 2'd0, 5'd0, 16'h0000, 16'h0500, 2'd1, 16'h0000, 16'h023F);

      // Asynchronous reset in the third SCAN cycle.
      @(negedge clk);
      v0 = vld_cnt;
      i_valid = 1'b1; i_st = 5'd2; i_at = 2'd0; i_next_st = 5'd0; i_rt = 16'h0100;
      @(posedge clk); #1 i_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_qmax", 32'(o_q_max), 32'h0500);
      rst_n = 1'b0;
      #1;
      chk("mrst_ready", 32'(o_ready), 32'd1);
      chk("mrst_valid", 32'(o_valid), 32'd0);
      chk("mrst_err",   32'(o_err),   32'd0);
      chk("mrst_amax",  32'(o_at_max), 32'd0);
      chk("mrst_qmax",  32'(o_q_max), 32'd0);
      chk("mrst_rdq",   32'(o_rd_q),  32'd0);
      @(negedge clk); rst_n = 1'b1;
      acc = '0;
      for (int s = 0; s < STATES; s++) begin
         for (int a = 0; a < ACTIONS; a++) begin
            @(negedge clk); i_rd_st = 5'(s); i_rd_at = 2'(a);
            @(negedge clk); acc = acc | o_rd_q;
         end
      end
      chk("mrst_table_zero", 32'(acc), 32'd0);
      chk("mrst_novalid", 32'(vld_cnt - v0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/q_table_update.md
# q_table_update

Q-learning value stage that consumes the transition tuple (state, action, reward, next state) produced by the grid-world controller, scans the four Q entries of the next state for the maximum, applies the fixed-point Bellman update to Q(state, action), and returns the greedy action for the next state to the controller. It holds the full Q table in registers and provides a registered readback port for table dumps.

## Interface
- STATES_WIDTH, 5, state index width (32 slots; 25 are legal)
- ACTIONS_WIDTH, 2, action index width (4 actions: 0 up, 1 down, 2 right, 3 left)
- DATA_WIDTH, 16, signed Q/reward word
- FRAC_BITS, 8, fractional bits of Q, reward and GAMMA
- STATES, 25, number of legal states
- GAMMA, 230, discount factor as an unsigned FRAC_BITS fraction (≈0.9)
- ALPHA_SHIFT, 1, learning rate = 2^-ALPHA_SHIFT
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  tuple valid; accepted only when o_ready=1
- i_st  in  STATES_WIDTH  current state
- i_at  in  ACTIONS_WIDTH  action taken
- i_rt  in  DATA_WIDTH  signed reward for i_next_st
- i_next_st  in  STATES_WIDTH  resulting state
- i_clear  in  1  zero the whole table (honoured in IDLE only)
- i_rd_st  in  STATES_WIDTH  readback state
- i_rd_at  in  ACTIONS_WIDTH  readback action
- o_ready  out  1  high in IDLE
- o_valid  out  1  one-cycle pulse: update written
- o_err  out  1  one-cycle pulse: tuple rejected
- o_at_max  out  ACTIONS_WIDTH  argmax action of last next state (to controller i_at_max)
- o_q_max  out  DATA_WIDTH  max Q of last next state
- o_rd_q  out  DATA_WIDTH  Q[i_rd_st][i_rd_at], registered

## Operation
- FSM: IDLE → SCAN (4 cycles, action index 0..3) → CALC → WRITE → DONE → IDLE.
- IDLE: o_ready=1. i_clear=1 zeroes all entries in one cycle and has priority over i_valid. i_valid=1 latches the tuple; if i_st ≥ STATES or i_next_st ≥ STATES, pulse o_err next cycle and stay IDLE, with no table write.
- SCAN: read Q[next_st][k] for k=0..3; running max is updated only on strictly greater, so ties resolve to the lowest action index.
- CALC: target = i_rt + ((GAMMA × q_max) >>> FRAC_BITS), computed at DATA_WIDTH+FRAC_BITS+2 bits and saturated to signed DATA_WIDTH; delta = target − Q[st][at] at DATA_WIDTH+1 bits.
- WRITE: Q[st][at] ← sat(Q[st][at] + (delta >>> ALPHA_SHIFT)) (arithmetic shift, truncation toward −∞).
- DONE: o_valid=1 for one cycle. o_at_max and o_q_max update in the same cycle and hold until the next DONE.
- st == next_st is legal: SCAN reads the pre-update values.
- i_valid and i_clear outside IDLE are ignored, with no buffering.
- Readback is independent of the FSM. If it targets the entry being written, it returns the pre-write value that cycle.

## Timing
- Accept edge = cycle 0; SCAN cycles 1–4; CALC 5; WRITE 6; o_valid high in cycle 7; o_ready high again in cycle 8.
- Throughput: one tuple per 8 cycles.
- o_err is asserted in cycle 1 after a rejected accept.
- o_rd_q: 1-cycle latency.
- Reset (asynchronous, any state, including mid-SCAN): table all zero, FSM IDLE, o_ready=1, o_valid=0, o_err=0, o_at_max=0, o_q_max=0, o_rd_q=0. An in-flight update is discarded.

## Structure
- Shared package (same params include as the controller): STATES_WIDTH, ACTIONS_WIDTH, DATA_WIDTH, FRAC_BITS, STATES, ACTIONS, GAMMA, ALPHA_SHIFT, action encodings, FSM state enum.
- One sub-module, q_sat_add: signed add plus saturation to DATA_WIDTH. It is used for both the target and the new Q value.

## Test plan
- Reset, then tuple st=0, at=1, next=5, rt=0x0A00 → o_valid in cycle 7, o_q_max=0, o_at_max=0, readback (0,1)=0x0500.
- Then st=5, at=0, next=0, rt=0 → o_at_max=1, o_q_max=0x0500, target=0x047E, readback (5,0)=0x023F.
- From reset, rt=0xF000 (−16.0) on st=3, at=1, next=8 → readback (3,1)=0xF800.
- Saturation: preload Q[8][*] via updates so q_max ≥ 0x4000, then rt=0x7FFF → target clamps to 0x7FFF; the new value is never wrapped negative.
- i_st=27 → o_err pulse in cycle 1, no o_valid, table unchanged; i_valid held high during SCAN → only one update occurs.
- rst_n low in cycle 3 of SCAN → all outputs at reset values, readback of every entry returns 0, no o_valid pulse.
